rf_read_stage_gen: RTL and testbench
====================================

Name: rf_read_stage_gen

Overview:
- Parametrised register-read stage: integrated register file, multi-source forwarding, load-use hazard detection and a registered RF/EX pipeline output with valid/ready handshake.
- Sits between instruction decode and EX.
- Operand selection is generalised over data width and register count.
- Adds behaviour not present in the current RF stage:
  - Stall and bubble insertion on load-use hazards.
  - Downstream backpressure.
  - Saturating hazard-stall counter.

Parameters:
DATA_W, 64, operand/register width in bits
NREGS, 32, number of architectural registers; ADDR_W = $clog2(NREGS)
ZERO_REG, NREGS-1, register index hard-wired to zero (reads 0, writes ignored)
CNT_W, 16, width of stall counter

Ports:
clk  in  1  clock; all state updates on rising edge
reset_n  in  1  asynchronous, active-low reset
in_valid  in  1  decoded instruction present
in_ready  out  1  stage accepts instruction this cycle
rn  in  ADDR_W  source A address
rm  in  ADDR_W  source B address (reg2loc=1)
rd  in  ADDR_W  destination; also source B when reg2loc=0 (store data)
reg2loc  in  1  selects B read address: 1=rm, 0=rd
alu_src  in  1  ALU B operand: 1=imm, 0=register B
imm  in  DATA_W  pre-extended immediate
uses_b  in  1  instruction reads source B (hazard check enable)
ex_wen  in  1  EX-stage instruction writes a register
ex_is_load  in  1  EX-stage instruction is a load
ex_addr  in  ADDR_W  EX destination
ex_data  in  DATA_W  EX result (ALU or MOV output, selected upstream)
mem_wen  in  1  MEM-stage writes a register
mem_addr  in  ADDR_W  MEM destination
mem_data  in  DATA_W  MEM result (load data or passed ALU result)
wb_wen  in  1  WB register write enable
wb_addr  in  ADDR_W  WB destination
wb_data  in  DATA_W  WB data
out_valid  out  1  pipeline register holds valid instruction
out_ready  in  1  EX accepts pipeline register contents
out_da  out  DATA_W  registered operand A
out_db  out  DATA_W  registered operand B (store data)
out_alub  out  DATA_W  registered ALU B operand
out_rd  out  ADDR_W  registered destination
stall_cnt  out  CNT_W  count of load-use stall cycles, saturating

Behaviour:
- Reset (reset_n=0, async):
  - All registers = 0.
  - out_valid=0; out_da/out_db/out_alub=0; out_rd=0; stall_cnt=0.
  - in_ready follows its combinational equation (=1 with out_valid=0 and no hazard).
- Register file:
  - NREGS x DATA_W.
  - Written on rising edge when wb_wen && wb_addr!=ZERO_REG.
  - Reads combinational.
- Read-address B = reg2loc ? rm : rd.
- Operand resolution per source, highest priority first:
  1. addr==ZERO_REG → 0. Never forwarded.
  2. ex_wen && ex_addr==addr && !ex_is_load → ex_data.
  3. mem_wen && mem_addr==addr → mem_data.
  4. wb_wen && wb_addr==addr → wb_data (same-cycle write-through).
  5. Otherwise → regfile[addr].
- alub = alu_src ? imm : resolved B.
- Hazard = in_valid && ex_wen && ex_is_load && ex_addr!=ZERO_REG && (ex_addr==rn || (uses_b && ex_addr==B addr)).
- adv = !out_valid || out_ready.
- in_ready = adv && !hazard.
- On the rising edge when adv:
  - in_valid && !hazard: capture resolved operands and rd; out_valid←1.
  - Hazard: out_valid←0 (bubble); instruction held upstream.
  - !in_valid: out_valid←0.
- When !adv: pipeline register holds all values; out_valid stays 1; in_ready=0.
- stall_cnt increments by 1 on each edge where hazard && adv; saturates at 2^CNT_W-1.
  - No increment while !adv: backpressure is not counted as a hazard stall.
- Latency: 1 cycle from accepted input to out_valid.
- Reset asserted mid-stall or mid-backpressure clears out_valid immediately. Upstream must re-present its instruction.
- Simultaneous WB write and read of same register returns wb_data in the same cycle; regfile updates at that edge.

Test Plan:
- Reset: reset_n=0 mid-operation with out_valid=1 → out_valid=0, stall_cnt=0 asynchronously; after release, reading x5 returns 0.
- Write-through: wb_wen=1, wb_addr=3, wb_data=0xAB; same cycle rn=3, in_valid=1 → next edge out_da=0xAB. A later read of x3 with no forwarding also returns 0xAB.
- Priority: ex(addr=4, data=0x11), mem(addr=4, data=0x22), wb(addr=4, data=0x33), rn=4 → out_da=0x11. With ex_wen=0 → 0x22.
- Zero register: ex_wen=1, ex_addr=31, ex_data=0xFF; rm=31, reg2loc=1 → out_db=0. wb write to 31 with 0x55 is ignored; subsequent read of 31 = 0.
- Load-use: ex_is_load=1, ex_addr=7, rn=7, out_ready=1 → in_ready=0, bubble (out_valid=0), stall_cnt=1. Next cycle ex_wen=0, mem(addr=7, data=0x99) → accepted, out_da=0x99.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles while new input is valid → outputs stable, in_ready=0, stall_cnt unchanged. out_ready=1 → new instruction captured on the next edge.

Source files
------------

// File: rtl/rf_read_stage_gen_if.sv
// Decode->RF and RF->EX handshake plus EX/MEM/WB forwarding taps for the register-read stage.
interface rf_read_stage_gen_if #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 16
);
   logic              in_valid;
   logic              in_ready;
   logic [ADDR_W-1:0] rn;
   logic [ADDR_W-1:0] rm;
   logic [ADDR_W-1:0] rd;
   logic              reg2loc;
   logic              alu_src;
   logic [DATA_W-1:0] imm;
   logic              uses_b;
   logic              ex_wen;
   logic              ex_is_load;
   logic [ADDR_W-1:0] ex_addr;
   logic [DATA_W-1:0] ex_data;
   logic              mem_wen;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_data;
   logic              wb_wen;
   logic [ADDR_W-1:0] wb_addr;
   logic [DATA_W-1:0] wb_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_da;
   logic [DATA_W-1:0] out_db;
   logic [DATA_W-1:0] out_alub;
   logic [ADDR_W-1:0] out_rd;
   logic [CNT_W-1:0]  stall_cnt;

   modport master (
      output in_valid, rn, rm, rd, reg2loc, alu_src, imm, uses_b,
             ex_wen, ex_is_load, ex_addr, ex_data, mem_wen, mem_addr, mem_data,
             wb_wen, wb_addr, wb_data, out_ready,
      input  in_ready, out_valid, out_da, out_db, out_alub, out_rd, stall_cnt
   );

   modport slave (
      input  in_valid, rn, rm, rd, reg2loc, alu_src, imm, uses_b,
             ex_wen, ex_is_load, ex_addr, ex_data, mem_wen, mem_addr, mem_data,
             wb_wen, wb_addr, wb_data, out_ready,
      output in_ready, out_valid, out_da, out_db, out_alub, out_rd, stall_cnt
   );
endinterface

// File: rtl/rf_read_stage_gen.sv
// Register-read stage: regfile, EX/MEM/WB forwarding, load-use stall and registered RF/EX handoff.

module rf_operand_resolve #(
   parameter int DATA_W   = 64,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 31
) (
   input  logic [ADDR_W-1:0] addr,
   input  logic              ex_wen,
   input  logic              ex_is_load,
   input  logic [ADDR_W-1:0] ex_addr,
   input  logic [DATA_W-1:0] ex_data,
   input  logic              mem_wen,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_data,
   input  logic              wb_wen,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   input  logic [DATA_W-1:0] rf_data,
   output logic [DATA_W-1:0] data
);
   localparam logic [ADDR_W-1:0] ZA = ADDR_W'(ZERO_REG);

   // Load results are not yet available in EX; the hazard logic stalls instead.
   always_comb begin
      data = rf_data;
      if (addr == ZA)                                 data = '0;
      else if (ex_wen && !ex_is_load && ex_addr == addr) data = ex_data;
      else if (mem_wen && mem_addr == addr)           data = mem_data;
      else if (wb_wen && wb_addr == addr)             data = wb_data;
   end
endmodule

module rf_read_stage_gen #(
   parameter int DATA_W   = 64,
   parameter int NREGS    = 32,
   parameter int ZERO_REG = NREGS-1,
   parameter int CNT_W    = 16
) (
   input logic             clk,
   input logic             reset_n,
   rf_read_stage_gen_if.slave bus
);
   localparam int ADDR_W = $clog2(NREGS);
   localparam logic [ADDR_W-1:0] ZA = ADDR_W'(ZERO_REG);

   logic [NREGS-1:0][DATA_W-1:0] rf;
   logic [1:0][ADDR_W-1:0]       src_addr;
   logic [1:0][DATA_W-1:0]       src_data;
   logic                         hazard, adv, accept;
   logic                         out_valid_q;
   logic [DATA_W-1:0]            da_q, db_q, alub_q;
   logic [ADDR_W-1:0]            rd_q;
   logic [CNT_W-1:0]             stall_q;

   assign src_addr[0] = bus.rn;
   assign src_addr[1] = bus.reg2loc ? bus.rm : bus.rd;

   for (genvar g = 0; g < 2; g++) begin : g_src
      rf_operand_resolve #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_res (
         .addr      (src_addr[g]),
         .ex_wen    (bus.ex_wen),
         .ex_is_load(bus.ex_is_load),
         .ex_addr   (bus.ex_addr),
         .ex_data   (bus.ex_data),
         .mem_wen   (bus.mem_wen),
         .mem_addr  (bus.mem_addr),
         .mem_data  (bus.mem_data),
         .wb_wen    (bus.wb_wen),
         .wb_addr   (bus.wb_addr),
         .wb_data   (bus.wb_data),
         .rf_data   (rf[src_addr[g]]),
         .data      (src_data[g])
      );
   end

   assign hazard = bus.in_valid && bus.ex_wen && bus.ex_is_load && (bus.ex_addr != ZA) &&
                   ((bus.ex_addr == src_addr[0]) || (bus.uses_b && bus.ex_addr == src_addr[1]));
   assign adv    = !out_valid_q || bus.out_ready;
   assign accept = adv && bus.in_valid && !hazard;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rf <= '0;
      end else if (bus.wb_wen && bus.wb_addr != ZA) begin
         rf[bus.wb_addr] <= bus.wb_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid_q <= 1'b0;
         da_q        <= '0;
         db_q        <= '0;
         alub_q      <= '0;
         rd_q        <= '0;
      end else if (adv) begin
         out_valid_q <= accept;
         if (accept) begin
            da_q   <= src_data[0];
            db_q   <= src_data[1];
            alub_q <= bus.alu_src ? bus.imm : src_data[1];
            rd_q   <= bus.rd;
         end
      end
   end

   // Backpressure cycles (adv=0) are deliberately excluded from the stall count.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                        stall_q <= '0;
      else if (hazard && adv && ~&stall_q) stall_q <= stall_q + CNT_W'(1);
   end

   assign bus.in_ready  = adv && !hazard;
   assign bus.out_valid = out_valid_q;
   assign bus.out_da    = da_q;
   assign bus.out_db    = db_q;
   assign bus.out_alub  = alub_q;
   assign bus.out_rd    = rd_q;
   assign bus.stall_cnt = stall_q;
endmodule

// File: tb/tb_rf_read_stage_gen.sv
// Directed bench: driver pushes expected RF/EX contents, negedge monitor pops on out handshake.
module tb_rf_read_stage_gen;
   typedef struct {
      logic [63:0] da, db, alub;
      logic [4:0]  rd;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n;
   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t sb[$];
   exp_t mon_e;
   logic [63:0] exp_stall;

   always #5 clk = ~clk;

   rf_read_stage_gen_if #(.DATA_W(64), .ADDR_W(5), .CNT_W(4)) bus();

   rf_read_stage_gen #(.DATA_W(64), .NREGS(32), .CNT_W(4)) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (reset_n && bus.out_valid && bus.out_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_out", 64'd1, 64'd0);
         end else begin
            mon_e = sb.pop_front();
            check("out_da",   bus.out_da,   mon_e.da);
            check("out_db",   bus.out_db,   mon_e.db);
            check("out_alub", bus.out_alub, mon_e.alub);
            check("out_rd",   64'(bus.out_rd), 64'(mon_e.rd));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic clr_fwd();
      bus.ex_wen = 0; bus.ex_is_load = 0; bus.ex_addr = 0; bus.ex_data = 0;
      bus.mem_wen = 0; bus.mem_addr = 0; bus.mem_data = 0;
      bus.wb_wen = 0; bus.wb_addr = 0; bus.wb_data = 0;
   endtask

   task automatic drive(input logic [4:0] rn_i, rm_i, rd_i, input logic r2l, asrc, ub,
                        input logic [63:0] imm_i);
      bus.in_valid = 1; bus.rn = rn_i; bus.rm = rm_i; bus.rd = rd_i;
      bus.reg2loc = r2l; bus.alu_src = asrc; bus.uses_b = ub; bus.imm = imm_i;
   endtask

   task automatic step(input logic exp_rdy, input logic [63:0] da, db, alub,
                       input logic [4:0] rd_e, input string nm);
      exp_t e;
      #1;
      check({nm, "_in_ready"}, 64'(bus.in_ready), 64'(exp_rdy));
      if (exp_rdy && bus.in_valid) begin
         e.da = da; e.db = db; e.alub = alub; e.rd = rd_e;
         sb.push_back(e);
      end
      @(posedge clk); #1;
   endtask

   task automatic idle_cycle();
      bus.in_valid = 0;
      @(posedge clk); #1;
   endtask

   initial begin
      reset_n = 0;
      clr_fwd();
      drive(0, 0, 0, 0, 0, 0, 0);
      bus.in_valid = 0;
      bus.out_ready = 1;
      exp_stall = 0;
      #12;
      check("rst_out_valid", 64'(bus.out_valid), 0);
      check("rst_stall",     64'(bus.stall_cnt), 0);
      check("rst_in_ready",  64'(bus.in_ready), 1);
      check("rst_out_da",    bus.out_da, 0);
      @(negedge clk) reset_n = 1;
      @(posedge clk); #1;

      drive(5, 5, 1, 1, 0, 0, 0);                       step(1, 0, 0, 0, 1, "rd_x5");
      // write-through
      bus.wb_wen = 1; bus.wb_addr = 3; bus.wb_data = 64'hAB;
      drive(3, 0, 2, 1, 1, 0, 64'h10);                  step(1, 64'hAB, 0, 64'h10, 2, "wt");
      clr_fwd(); drive(0, 3, 3, 1, 0, 0, 0);            step(1, 0, 64'hAB, 64'hAB, 3, "rf_x3");
      // forwarding priority
      bus.ex_wen = 1; bus.ex_addr = 4; bus.ex_data = 64'h11;
      bus.mem_wen = 1; bus.mem_addr = 4; bus.mem_data = 64'h22;
      bus.wb_wen = 1; bus.wb_addr = 4; bus.wb_data = 64'h33;
      drive(4, 9, 4, 1, 0, 0, 0);                       step(1, 64'h11, 0, 0, 4, "prio_ex");
      bus.ex_wen = 0;                                   step(1, 64'h22, 0, 0, 4, "prio_mem");
      clr_fwd(); drive(4, 0, 4, 0, 0, 1, 0);            step(1, 64'h33, 64'h33, 64'h33, 4, "rf_x4");
      // zero register
      bus.ex_wen = 1; bus.ex_addr = 31; bus.ex_data = 64'hFF;
      bus.wb_wen = 1; bus.wb_addr = 31; bus.wb_data = 64'h55;
      drive(31, 31, 5, 1, 0, 1, 0);                     step(1, 0, 0, 0, 5, "zero_fwd");
      clr_fwd(); drive(31, 31, 6, 1, 0, 1, 0);          step(1, 0, 0, 0, 6, "zero_rf");
      // load-use on A
      bus.ex_wen = 1; bus.ex_is_load = 1; bus.ex_addr = 7;
      drive(7, 0, 8, 1, 0, 0, 0);                       step(0, 0, 0, 0, 0, "lu_hz");
      exp_stall++;
      check("lu_bubble", 64'(bus.out_valid), 0);
      check("lu_stall",  64'(bus.stall_cnt), exp_stall);
      bus.ex_wen = 0; bus.ex_is_load = 0;
      bus.mem_wen = 1; bus.mem_addr = 7; bus.mem_data = 64'h99;
      step(1, 64'h99, 0, 0, 8, "lu_fwd");
      clr_fwd();
      // load-use on B depends on uses_b; load data never forwarded from EX
      bus.ex_wen = 1; bus.ex_is_load = 1; bus.ex_addr = 8; bus.ex_data = 64'hEE;
      drive(1, 8, 9, 1, 0, 1, 0);                       step(0, 0, 0, 0, 0, "lub_hz");
      exp_stall++;
      check("lub_stall", 64'(bus.stall_cnt), exp_stall);
      drive(1, 8, 9, 1, 0, 0, 0);                       step(1, 0, 0, 0, 9, "lub_nohz");
      bus.ex_addr = 31;
      drive(31, 31, 10, 1, 0, 1, 0);                    step(1, 0, 0, 0, 10, "lz");
      clr_fwd();
      // backpressure
      drive(3, 4, 11, 1, 1, 1, 64'h77);                 step(1, 64'hAB, 64'h33, 64'h77, 11, "bp_x");
      bus.out_ready = 0;
      drive(4, 3, 12, 1, 0, 1, 0);
      for (int i = 0; i < 3; i++) begin
         if (i == 1) begin bus.ex_wen = 1; bus.ex_is_load = 1; bus.ex_addr = 4; end
         else clr_fwd();
         step(0, 0, 0, 0, 0, "bp_hold");
         check("bp_valid", 64'(bus.out_valid), 1);
         check("bp_da",    bus.out_da, 64'hAB);
         check("bp_alub",  bus.out_alub, 64'h77);
         check("bp_rd",    64'(bus.out_rd), 11);
         check("bp_stall", 64'(bus.stall_cnt), exp_stall);
      end
      clr_fwd(); bus.out_ready = 1;
      step(1, 64'h33, 64'hAB, 64'hAB, 12, "bp_y");
      idle_cycle();
      // saturation of the 4-bit stall counter
      bus.ex_wen = 1; bus.ex_is_load = 1; bus.ex_addr = 2;
      drive(2, 0, 0, 1, 0, 0, 0);
      for (int i = 0; i < 16; i++) begin
         step(0, 0, 0, 0, 0, "sat_hz");
         if (exp_stall != 15) exp_stall++;
         check("sat_stall", 64'(bus.stall_cnt), exp_stall);
      end
      clr_fwd(); idle_cycle();
      // async reset during backpressure
      drive(5, 5, 13, 1, 0, 1, 0);                      step(1, 0, 0, 0, 13, "pre_rst");
      bus.out_ready = 0; bus.in_valid = 0;
      #2 reset_n = 0;
      #1;
      check("mid_rst_valid", 64'(bus.out_valid), 0);
      check("mid_rst_stall", 64'(bus.stall_cnt), 0);
      sb.delete();
      @(negedge clk) reset_n = 1;
      bus.out_ready = 1;
      @(posedge clk); #1;
      drive(5, 3, 14, 1, 0, 1, 0);                      step(1, 0, 0, 0, 14, "post_rst");
      idle_cycle();
      idle_cycle();
      check("sb_drain", 64'(sb.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
